// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM responder (23LC512-style, sequential mode).
// SPI pins are oversampled in the clk domain; contents live in a byte array.
module spi_sram_responder #(
  parameter int          MEM_BYTES  = 256,
  parameter logic [7:0]  STATUS_VAL = 8'h40
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic bad_cmd
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [3:0] {
    IDLE, CMD, RADDR, WADDR, READ, WRITE, RDSR, WRSR, IGNORE
  } state_t;

  logic [7:0] mem [MEM_BYTES];

  logic [1:0] sck_s, cs_s, mosi_s;
  logic       sck_q;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            miso_q, miso_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            bad_q, bad_d;
  logic            wr_pend_q, wr_pend_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;

  logic          cs_n, mosi, rise, fall, last8;
  logic [AW:0]   addr_ext;
  logic [AW-1:0] addr_in, addr_inc;
  logic [7:0]    byte_in;

  assign cs_n     = cs_s[1];
  assign mosi     = mosi_s[1];
  assign rise     = sck_s[1] & ~sck_q & ~cs_n;
  assign fall     = ~sck_s[1] & sck_q & ~cs_n;
  assign last8    = (cnt_q == 4'd7);
  assign addr_ext = {addr_q, mosi};
  assign addr_in  = addr_ext[AW-1:0];
  assign addr_inc = addr_q + AW'(1);
  assign byte_in  = {sh_q[6:0], mosi};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    bad_d     = 1'b0;
    wr_pend_d = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    // deselect wins over any sck edge seen in the same cycle
    if (state_q != IDLE && cs_n) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs_n) begin
            state_d = CMD;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (last8) begin
              cnt_d = '0;
              case (byte_in)
                8'h03: state_d = RADDR;
                8'h02: state_d = WADDR;
                8'h05: begin
                  state_d = RDSR;
                  sh_d    = STATUS_VAL;
                end
                8'h01: state_d = WRSR;
                default: begin
                  state_d = IGNORE;
                  bad_d   = 1'b1;
                end
              endcase
            end
          end
        end
        RADDR, WADDR: begin
          if (rise) begin
            addr_d = addr_in;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              cnt_d = '0;
              if (state_q == RADDR) begin
                state_d = READ;
                sh_d    = mem[addr_in];
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        READ, RDSR: begin
          if (fall) begin
            miso_d = sh_q[7];
            oe_d   = 1'b1;
            sh_d   = {sh_q[6:0], 1'b0};
          end else if (rise) begin
            cnt_d = cnt_q + 4'd1;
            if (last8) begin
              cnt_d = '0;
              if (state_q == READ) begin
                addr_d = addr_inc;
                sh_d   = mem[addr_inc];
              end else begin
                sh_d = STATUS_VAL;
              end
            end
          end
        end
        WRITE: begin
          if (rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (last8) begin
              cnt_d     = '0;
              wr_pend_d = 1'b1;
              wr_data_d = byte_in;
              wr_addr_d = addr_q;
              addr_d    = addr_inc;
            end
          end
        end
        WRSR, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s     <= '0;
      cs_s      <= '1;
      mosi_s    <= '0;
      sck_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      bad_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      sck_s     <= {sck_s[0], spi_sck};
      cs_s      <= {cs_s[0], spi_cs_n};
      mosi_s    <= {mosi_s[0], spi_mosi};
      sck_q     <= sck_s[1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      bad_q     <= bad_d;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // contents survive reset; a completed byte lands one cycle after its 8th edge
  always_ff @(posedge clk) begin
    if (wr_pend_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign bad_cmd     = bad_q;

endmodule
